ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_pkg.sv | 25 ++
 rtl/ram_ctrl_if.sv | 30 +++
 rtl/ram_refresh_timer.sv | 31 +++
 rtl/ram_ctrl.sv | 150 +++++++++++++++
 tb/tb_ram_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the FSB DRAM controller.
package ram_ctrl_pkg;

  localparam int unsigned RA_WIDTH             = 12;
  localparam int unsigned DEF_REFRESH_INTERVAL = 250;
  localparam int unsigned DEF_RAS_PRE          = 2;
  localparam int unsigned REF_CNT_WIDTH        = 12;
  localparam int unsigned PRE_CNT_WIDTH        = 3;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    HOLD,
    PRE,
    RCAS,
    RRAS,
    RHOLD
  } ramStateT;

  function automatic logic isRefreshState(input ramStateT s);
    return (s == RCAS) || (s == RRAS) || (s == RHOLD);
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// FSB-side request signals and DRAM-side strobes of the RAM controller.
interface ram_ctrl_if;
  import ram_ctrl_pkg::*;

  logic [23:1]         A_FSB;
  logic                nAS_FSB;
  logic                nUDS_FSB;
  logic                nLDS_FSB;
  logic                nWE_FSB;
  logic                RAMSEL;
  logic [RA_WIDTH-1:0] RA;
  logic                nRAS;
  logic                nCAS;
  logic                nOE;
  logic                nRAMUWE;
  logic                nRAMLWE;
  logic                RAMRDY;
  logic                REFBUSY;

  modport master (
    output A_FSB, nAS_FSB, nUDS_FSB, nLDS_FSB, nWE_FSB, RAMSEL,
    input  RA, nRAS, nCAS, nOE, nRAMUWE, nRAMLWE, RAMRDY, REFBUSY
  );

  modport slave (
    input  A_FSB, nAS_FSB, nUDS_FSB, nLDS_FSB, nWE_FSB, RAMSEL,
    output RA, nRAS, nCAS, nOE, nRAMUWE, nRAMLWE, RAMRDY, REFBUSY
  );

endinterface

// File: rtl/ram_refresh_timer.sv
// Free-running refresh interval counter with a single-deep pending request.
module ram_refresh_timer
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic clk,
  input  logic nReset,
  input  logic ack,
  output logic pending
);

  localparam logic [REF_CNT_WIDTH-1:0] RELOAD = REF_CNT_WIDTH'(REFRESH_INTERVAL - 1);

  logic [REF_CNT_WIDTH-1:0] count;
  logic                     expire;

  assign expire = (count == '0);

  // An expiry on the acknowledge edge is a fresh request, so it wins over ack.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      count   <= RELOAD;
      pending <= 1'b0;
    end else begin
      count   <= expire ? RELOAD : count - 1'b1;
      pending <= expire | (pending & ~ack);
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// DRAM controller for the FSB: row/column multiplexing, CPU access cycles
// and CAS-before-RAS refresh, all outputs registered.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int unsigned RAS_PRE          = DEF_RAS_PRE
) (
  input  logic       CLK_FSB,
  input  logic       nRESETin,
  ram_ctrl_if.slave  fsb
);

  localparam logic [PRE_CNT_WIDTH-1:0] PRE_LOAD = PRE_CNT_WIDTH'(RAS_PRE - 1);

  ramStateT                 state, stateNext;
  logic [RA_WIDTH-1:0]      ra, raNext;
  logic                     nRas, nRasNext;
  logic                     nCas, nCasNext;
  logic                     nOe, nOeNext;
  logic                     nUwe, nUweNext;
  logic                     nLwe, nLweNext;
  logic                     rdy, rdyNext;
  logic [PRE_CNT_WIDTH-1:0] preCnt, preCntNext;
  logic                     refActive;
  logic                     refAck;
  logic                     refPending;

  ram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) uRefresh (
    .clk    (CLK_FSB),
    .nReset (nRESETin),
    .ack    (refAck),
    .pending(refPending)
  );

  always_ff @(posedge CLK_FSB) begin
    if (!nRESETin) begin
      state     <= IDLE;
      ra        <= '0;
      nRas      <= 1'b1;
      nCas      <= 1'b1;
      nOe       <= 1'b1;
      nUwe      <= 1'b1;
      nLwe      <= 1'b1;
      rdy       <= 1'b0;
      preCnt    <= '0;
      refActive <= 1'b0;
    end else begin
      state     <= stateNext;
      ra        <= raNext;
      nRas      <= nRasNext;
      nCas      <= nCasNext;
      nOe       <= nOeNext;
      nUwe      <= nUweNext;
      nLwe      <= nLweNext;
      rdy       <= rdyNext;
      preCnt    <= preCntNext;
      refActive <= isRefreshState(stateNext);
    end
  end

  always_comb begin
    stateNext  = state;
    raNext     = ra;
    nRasNext   = nRas;
    nCasNext   = nCas;
    nOeNext    = nOe;
    nUweNext   = nUwe;
    nLweNext   = nLwe;
    rdyNext    = rdy;
    preCntNext = preCnt;
    refAck     = 1'b0;

    case (state)
      IDLE: begin
        raNext = fsb.A_FSB[23:12];
        // Refresh is checked first so a same-edge CPU request waits.
        if (refPending) begin
          stateNext = RCAS;
          nCasNext  = 1'b0;
          refAck    = 1'b1;
        end else if (fsb.RAMSEL && !fsb.nAS_FSB) begin
          stateNext = ROW;
          nRasNext  = 1'b0;
        end
      end
      ROW: begin
        raNext    = {1'b0, fsb.A_FSB[11:1]};
        stateNext = COL;
      end
      COL: begin
        nCasNext  = 1'b0;
        rdyNext   = 1'b1;
        nOeNext   = ~fsb.nWE_FSB;
        nUweNext  = ~(~fsb.nWE_FSB & ~fsb.nUDS_FSB);
        nLweNext  = ~(~fsb.nWE_FSB & ~fsb.nLDS_FSB);
        stateNext = HOLD;
      end
      HOLD: begin
        if (fsb.nAS_FSB) begin
          nRasNext   = 1'b1;
          nCasNext   = 1'b1;
          nOeNext    = 1'b1;
          nUweNext   = 1'b1;
          nLweNext   = 1'b1;
          rdyNext    = 1'b0;
          preCntNext = PRE_LOAD;
          stateNext  = PRE;
        end
      end
      PRE: begin
        nRasNext = 1'b1;
        nCasNext = 1'b1;
        if (preCnt == '0) begin
          stateNext = IDLE;
        end else begin
          preCntNext = preCnt - 1'b1;
        end
      end
      RCAS: begin
        nRasNext  = 1'b0;
        stateNext = RRAS;
      end
      RRAS: begin
        stateNext = RHOLD;
      end
      RHOLD: begin
        nRasNext   = 1'b1;
        nCasNext   = 1'b1;
        preCntNext = PRE_LOAD;
        stateNext  = PRE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign fsb.RA      = ra;
  assign fsb.nRAS    = nRas;
  assign fsb.nCAS    = nCas;
  assign fsb.nOE     = nOe;
  assign fsb.nRAMUWE = nUwe;
  assign fsb.nRAMLWE = nLwe;
  assign fsb.RAMRDY  = rdy;
  assign fsb.REFBUSY = refPending | refActive;

endmodule

// File: tb/tb_ram_ctrl.sv
// Randomized FSB traffic against a transaction-level model of the RAM controller.
module tb_ram_ctrl;

  localparam int RI = 250;
  localparam int RP = 2;

  localparam int OP_NONE = 0;
  localparam int OP_CPU  = 1;
  localparam int OP_REF  = 2;

  logic clk = 1'b0;
  logic nRst;

  always #5 clk = ~clk;

  ram_ctrl_if bus();

  ram_ctrl #(
    .REFRESH_INTERVAL(RI),
    .RAS_PRE         (RP)
  ) dut (
    .CLK_FSB (clk),
    .nRESETin(nRst),
    .fsb     (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Drive values for the next rising edge.
  logic        drvRst;
  logic [23:1] drvA;
  logic        drvAs, drvUds, drvLds, drvWe, drvSel;

  // Model: refresh timer, current operation with step within it, precharge left.
  int         mTmr, mOp, mStep, mPre;
  logic       mPend;
  logic [11:0] mRA;
  logic       mRas, mCas, mOe, mUwe, mLwe, mRdy;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelEdge();
    logic oldPend, ackNow, expire;
    if (!nRst) begin
      mTmr = RI - 1; mPend = 1'b0;
      mOp = OP_NONE; mStep = 0; mPre = 0;
      mRA = '0;
      mRas = 1'b1; mCas = 1'b1; mOe = 1'b1; mUwe = 1'b1; mLwe = 1'b1;
      mRdy = 1'b0;
      return;
    end
    oldPend = mPend;
    ackNow  = 1'b0;
    if (mPre > 0) begin
      mPre--;
    end else if (mOp == OP_NONE) begin
      mRA = bus.A_FSB[23:12];
      if (oldPend) begin
        mOp = OP_REF; mStep = 1; mCas = 1'b0; ackNow = 1'b1;
      end else if (bus.RAMSEL && !bus.nAS_FSB) begin
        mOp = OP_CPU; mStep = 1; mRas = 1'b0;
      end
    end else if (mOp == OP_CPU) begin
      if (mStep == 1) begin
        mRA = {1'b0, bus.A_FSB[11:1]};
        mStep = 2;
      end else if (mStep == 2) begin
        mCas = 1'b0; mRdy = 1'b1;
        mOe  = !bus.nWE_FSB;
        mUwe = !(!bus.nWE_FSB && !bus.nUDS_FSB);
        mLwe = !(!bus.nWE_FSB && !bus.nLDS_FSB);
        mStep = 3;
      end else if (bus.nAS_FSB) begin
        mRas = 1'b1; mCas = 1'b1; mOe = 1'b1; mUwe = 1'b1; mLwe = 1'b1;
        mRdy = 1'b0;
        mOp = OP_NONE; mPre = RP;
      end
    end else begin
      if (mStep == 1) mRas = 1'b0;
      if (mStep == 3) begin
        mRas = 1'b1; mCas = 1'b1;
        mOp = OP_NONE; mPre = RP;
      end else begin
        mStep++;
      end
    end
    expire = (mTmr == 0);
    mTmr   = expire ? RI - 1 : mTmr - 1;
    mPend  = expire || (mPend && !ackNow);
  endtask

  task automatic compareAll();
    logic expBusy;
    expBusy = mPend || (mOp == OP_REF);
    checkVal("RA",      32'(bus.RA),      32'(mRA));
    checkVal("nRAS",    32'(bus.nRAS),    32'(mRas));
    checkVal("nCAS",    32'(bus.nCAS),    32'(mCas));
    checkVal("nOE",     32'(bus.nOE),     32'(mOe));
    checkVal("nRAMUWE", 32'(bus.nRAMUWE), 32'(mUwe));
    checkVal("nRAMLWE", 32'(bus.nRAMLWE), 32'(mLwe));
    checkVal("RAMRDY",  32'(bus.RAMRDY),  32'(mRdy));
    checkVal("REFBUSY", 32'(bus.REFBUSY), 32'(expBusy));
  endtask

  task automatic applyInputs();
    nRst         = drvRst;
    bus.A_FSB    = drvA;
    bus.nAS_FSB  = drvAs;
    bus.nUDS_FSB = drvUds;
    bus.nLDS_FSB = drvLds;
    bus.nWE_FSB  = drvWe;
    bus.RAMSEL   = drvSel;
  endtask

  task automatic tick();
    @(negedge clk);
    compareAll();
    applyInputs();
    modelEdge();
  endtask

  task automatic idleInputs();
    drvAs = 1'b1; drvSel = 1'b0; drvWe = 1'b1; drvUds = 1'b1; drvLds = 1'b1;
  endtask

  task automatic pickStrobes();
    int r;
    drvWe = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 2);
    drvUds = (r == 2);
    drvLds = (r == 1);
  endtask

  // Releases reset with an idle bus and times the first refresh from edge 1.
  task automatic refreshTiming(input string tag);
    int busyAt = 0;
    int casAt = 0;
    int bothLow = 0;
    drvRst = 1'b1;
    idleInputs();
    tick();
    for (int i = 1; i <= RI + 20; i++) begin
      tick();
      if (busyAt == 0 && bus.REFBUSY === 1'b1) busyAt = i;
      if (casAt == 0 && bus.nCAS === 1'b0) casAt = i;
      if (bus.nCAS === 1'b0 && bus.nRAS === 1'b0) bothLow++;
    end
    checkVal({tag, "_busyAt"},  32'(busyAt),  32'(RI));
    checkVal({tag, "_casAt"},   32'(casAt),   32'(RI + 1));
    checkVal({tag, "_bothLow"}, 32'(bothLow), 32'd2);
    checkVal({tag, "_busyEnd"}, 32'(bus.REFBUSY), 32'd0);
  endtask

  task automatic cpuCycle();
    int lowN, highN;
    lowN  = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 30) : $urandom_range(1, 8);
    highN = $urandom_range(1, 4);
    drvA   = 23'($urandom);
    drvSel = ($urandom_range(0, 7) != 0);
    pickStrobes();
    drvAs = 1'b0;
    for (int i = 0; i < lowN; i++) begin
      // Late strobe changes must not reach the DRAM once the column is issued.
      if (i > 0 && $urandom_range(0, 3) == 0) pickStrobes();
      tick();
    end
    drvAs = 1'b1;
    for (int i = 0; i < highN; i++) tick();
  endtask

  initial begin
    logic found;
    drvRst = 1'b0;
    drvA   = '0;
    idleInputs();
    applyInputs();
    modelEdge();
    repeat (3) tick();

    refreshTiming("por");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        drvRst = 1'b0;
        tick();
        drvRst = 1'b1;
      end
      cpuCycle();
    end

    idleInputs();
    found = 1'b0;
    for (int i = 0; i < 2 * RI && !found; i++) begin
      tick();
      if (mOp == OP_REF && mStep == 2) found = 1'b1;
    end
    checkVal("rras_found", 32'(found), 32'd1);
    drvRst = 1'b0;
    tick();
    tick();
    checkVal("rst_strobes", 32'({bus.nRAS, bus.nCAS, bus.nOE, bus.nRAMUWE, bus.nRAMLWE}), 32'h1f);
    checkVal("rst_rdy",     32'(bus.RAMRDY),  32'd0);
    checkVal("rst_busy",    32'(bus.REFBUSY), 32'd0);
    checkVal("rst_ra",      32'(bus.RA),      32'd0);
    refreshTiming("rras_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
